mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/tinker_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/tinker_pkg.sv
// tinker_pkg: shared widths and arbiter state encoding
package tinker_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for a single-port memory with fixed latency and fetch anti-starvation
module mem_arbiter
  import tinker_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [ILEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t      state;
  logic [2:0]      busy_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            flushed;
  logic [ILEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;
  logic            idle, last, starved;
  always_comb begin
    idle      = state == IDLE && !reset;
    starved   = starve_cnt == SW'(STARVE_MAX);
    if_gnt    = idle && if_req && (!d_req || starved);
    d_gnt     = idle && d_req && !if_gnt;
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    last      = busy_cnt == 3'd1 && !reset;
    if_rvalid = state == BUSY_I && last && !flushed && !if_flush;
    d_rvalid  = state == BUSY_D && last;
    if_rdata  = if_rvalid ? mem_rdata[ILEN-1:0] : if_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy_cnt   <= '0;
      starve_cnt <= '0;
      flushed    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (mem_en) begin
        state      <= if_gnt ? BUSY_I : BUSY_D;
        busy_cnt   <= 3'(MEM_LAT);
        flushed    <= 1'b0;
        starve_cnt <= if_gnt ? '0 : (if_req && !starved) ? starve_cnt + 1'b1 : starve_cnt;
      end else if (state != IDLE) begin
        busy_cnt <= busy_cnt - 3'd1;
        if (busy_cnt == 3'd1) state <= IDLE;
        if (state == BUSY_I && if_flush) flushed <= 1'b1;
      end
      if (if_rvalid) if_rdata_q <= mem_rdata[ILEN-1:0];
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end
endmodule
